// File: rtl/cpu64_l1_plru_n.sv
// Tree-PLRU replacement engine for the L1 arrays, any power-of-two way count.
// Holds WAYS-1 tree bits per set (heap nodes 1..WAYS-1, 0 = left subtree LRU).
// A victim request is answered one cycle later through registered outputs.
// An init sweep clears one set per cycle after reset or on init_i.
// Optional build macro: CPU64_L1_PLRU_VICTIM_TOUCH_EN. When it is defined, a
// delivered victim is touched automatically so that repeated misses to one set
// rotate through its ways.
module cpu64_l1_plru_n #(
    parameter int unsigned SETS    = 64,
    parameter int unsigned WAYS    = 8,
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned WAY_W   = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               init_i,
    output logic               busy_o,
    input  logic               access_i,
    input  logic [INDEX_W-1:0] access_set_i,
    input  logic [WAY_W-1:0]   access_way_i,
    input  logic               victim_req_i,
    input  logic [INDEX_W-1:0] victim_set_i,
    input  logic [WAYS-1:0]    valid_i,
    input  logic [WAYS-1:0]    lock_i,
    output logic               victim_vld_o,
    output logic [WAY_W-1:0]   victim_way_o,
    output logic               victim_none_o
);

    typedef enum logic [0:0] {StIdle, StInit} state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic               busy;

    logic [WAYS-1:1]    tree_q [SETS];

    logic [WAYS-1:1]    vic_tree;
    logic [WAYS-1:0]    cand;
    logic [WAY_W-1:0]   vic_way;
    logic               vic_none;
    logic               req_ok;

    logic               vld_q;
    logic [WAY_W-1:0]   way_q;
    logic               none_q;

`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
    logic [INDEX_W-1:0] vset_q;
    logic               auto_touch;
`endif

    // Mark way w MRU: each node on its path points away from the path taken.
    function automatic logic [WAYS-1:1] touch_fn(input logic [WAYS-1:1] t,
                                                 input logic [WAY_W-1:0] w);
        logic [WAYS-1:1] r;
        int unsigned     n;
        r = t;
        n = 1;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            r[n] = ~w[WAY_W-1-l];
            n    = (n << 1) | {31'b0, w[WAY_W-1-l]};
        end
        return r;
    endfunction

    // Follow the LRU pointers, steering away from fully locked subtrees.
    function automatic logic [WAY_W-1:0] walk_fn(input logic [WAYS-1:1] t,
                                                 input logic [WAYS-1:0] lock);
        int unsigned n, base, span, half;
        logic        go_right, left_locked, right_locked;
        n    = 1;
        base = 0;
        span = WAYS;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            half         = span >> 1;
            left_locked  = 1'b1;
            right_locked = 1'b1;
            for (int unsigned i = 0; i < WAYS; i++) begin
                if (i >= base && i < base + half && !lock[i]) left_locked = 1'b0;
                if (i >= base + half && i < base + span && !lock[i]) right_locked = 1'b0;
            end
            go_right = t[n];
            if (go_right && right_locked) begin
                go_right = 1'b0;
            end else if (!go_right && left_locked) begin
                go_right = 1'b1;
            end
            if (go_right) base = base + half;
            n    = (n << 1) | {31'b0, go_right};
            span = half;
        end
        return WAY_W'(base);
    endfunction

    // Reset is folded into busy so the reset cycle itself reports busy.
    assign busy   = rst_i | (state_q == StInit);
    assign busy_o = busy;
    assign req_ok = victim_req_i & ~busy;

`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
    // An explicit touch to the same set in the pulse cycle overrides the auto-touch.
    assign auto_touch = vld_q & ~none_q & ~busy & ~(access_i & (access_set_i == vset_q));
`endif

    // Init FSM next state: sweep counter runs 0..SETS-1, init_i restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (init_i) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            StInit: begin
                if (init_i) begin
                    cnt_d = '0;
                end else if (cnt_q == INDEX_W'(SETS - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Init FSM state register with synchronous reset into the sweep.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Victim selection: lowest free way first, otherwise the lock-aware tree walk.
    always_comb begin
        vic_tree = tree_q[victim_set_i];
`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
        // Forward the auto-touch so a back-to-back request sees it.
        if (auto_touch && (vset_q == victim_set_i)) begin
            vic_tree = touch_fn(vic_tree, way_q);
        end
`endif
        cand     = ~valid_i & ~lock_i;
        vic_none = &lock_i;
        vic_way  = walk_fn(vic_tree, lock_i);
        if (|cand) begin
            for (int i = WAYS - 1; i >= 0; i--) begin
                if (cand[i]) vic_way = WAY_W'(i);
            end
        end
        if (vic_none) vic_way = '0;
    end

    // Victim response registers: one pulse per accepted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            way_q  <= '0;
            none_q <= 1'b0;
`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
            vset_q <= '0;
`endif
        end else begin
            vld_q <= req_ok;
            if (req_ok) begin
                way_q  <= vic_way;
                none_q <= vic_none;
`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
                vset_q <= victim_set_i;
`endif
            end
        end
    end

    // Tree storage: cleared by the sweep, otherwise updated by touches.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == StInit) begin
                tree_q[cnt_q] <= '0;
            end else begin
`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
                if (auto_touch) tree_q[vset_q] <= touch_fn(tree_q[vset_q], way_q);
`endif
                if (access_i) begin
                    tree_q[access_set_i] <= touch_fn(tree_q[access_set_i], access_way_i);
                end
            end
        end
    end

    assign victim_vld_o  = vld_q;
    assign victim_way_o  = way_q;
    assign victim_none_o = none_q;

endmodule

// File: tb/tb_cpu64_l1_plru_n.sv
// Scoreboard bench for cpu64_l1_plru_n: directed cases plus random traffic
// checked against a heap-arithmetic tree-PLRU model.
module tb_cpu64_l1_plru_n;

    localparam int SETS    = 64;
    localparam int WAYS    = 8;
    localparam int INDEX_W = 6;
    localparam int WAY_W   = 3;

    logic               clk = 1'b0;
    logic               rst_i = 1'b0;
    logic               init_i = 1'b0;
    logic               busy_o;
    logic               access_i = 1'b0;
    logic [INDEX_W-1:0] access_set_i = '0;
    logic [WAY_W-1:0]   access_way_i = '0;
    logic               victim_req_i = 1'b0;
    logic [INDEX_W-1:0] victim_set_i = '0;
    logic [WAYS-1:0]    valid_i = '0;
    logic [WAYS-1:0]    lock_i = '0;
    logic               victim_vld_o;
    logic [WAY_W-1:0]   victim_way_o;
    logic               victim_none_o;

    cpu64_l1_plru_n #(
        .SETS(SETS), .WAYS(WAYS), .INDEX_W(INDEX_W), .WAY_W(WAY_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .init_i       (init_i),
        .busy_o       (busy_o),
        .access_i     (access_i),
        .access_set_i (access_set_i),
        .access_way_i (access_way_i),
        .victim_req_i (victim_req_i),
        .victim_set_i (victim_set_i),
        .valid_i      (valid_i),
        .lock_i       (lock_i),
        .victim_vld_o (victim_vld_o),
        .victim_way_o (victim_way_o),
        .victim_none_o(victim_none_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int way;
        bit none;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: node bit per heap index, 0 = left subtree LRU.
    bit   m_tree [SETS][WAYS];
    int   busy_left = 0;
    bit   pend_v = 0;
    int   pend_set = 0;
    int   pend_way = 0;

    // Walk up from the leaf; each parent points at the sibling of the child we came from.
    function automatic void m_touch(int s, int w);
        int x = w + WAYS;
        while (x > 1) begin
            m_tree[s][x >> 1] = (x % 2 == 1) ? 1'b0 : 1'b1;
            x = x >> 1;
        end
    endfunction

    function automatic bit m_all_locked(int m, logic [WAYS-1:0] lk);
        for (int w = 0; w < WAYS; w++) begin
            int x = w + WAYS;
            while (x > m) x = x >> 1;
            if (x == m && !lk[w]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int m_victim(int s, logic [WAYS-1:0] vm, logic [WAYS-1:0] lk,
                                    output bit none);
        int node;
        none = (lk == {WAYS{1'b1}});
        if (none) return 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vm[w] && !lk[w]) return w;
        end
        node = 1;
        while (node < WAYS) begin
            int pref = 2 * node + int'(m_tree[s][node]);
            if (m_all_locked(pref, lk)) pref = pref ^ 1;
            node = pref;
        end
        return node - WAYS;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS; n++) m_tree[s][n] = 1'b0;
    endfunction

    // One clock of stimulus; called just after a rising edge.
    task automatic drive_cycle(input bit rst, input bit init, input bit acc, input int aset,
                               input int aw, input bit req, input int vset,
                               input logic [WAYS-1:0] vm, input logic [WAYS-1:0] lk,
                               input bit use_exp, input int exp_way, input bit exp_none);
        bit   mbusy;
        bit   push;
        bit   new_pend;
        bit   none;
        int   way;
        exp_t e;
        rst_i        = rst;
        init_i       = init;
        access_i     = acc;
        access_set_i = INDEX_W'(aset);
        access_way_i = WAY_W'(aw);
        victim_req_i = req;
        victim_set_i = INDEX_W'(vset);
        valid_i      = vm;
        lock_i       = lk;
        mbusy        = rst || (busy_left > 0);
        #1;
        checks++;
        if (busy_o !== mbusy) begin
            errors++;
            $display("FAIL busy: busy_o=%0b expected %0b at %0t", busy_o, mbusy, $time);
        end
        push     = 1'b0;
        new_pend = 1'b0;
        if (!mbusy) begin
`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
            if (pend_v && !(acc && aset == pend_set)) m_touch(pend_set, pend_way);
`endif
            if (req) begin
                way  = m_victim(vset, vm, lk, none);
                push = 1'b1;
                e.way  = use_exp ? exp_way : way;
                e.none = use_exp ? exp_none : none;
                new_pend = !none;
                pend_set = vset;
                pend_way = way;
            end
            if (acc) m_touch(aset, aw);
        end
        pend_v = new_pend;
        if (rst || init) begin
            busy_left = SETS;
            m_clear();
        end else if (busy_left > 0) begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, '1, '0, 0, 0, 0);
    endtask

    task automatic req_exp(input int s, input logic [WAYS-1:0] vm, input logic [WAYS-1:0] lk,
                           input int w, input bit none);
        drive_cycle(0, 0, 0, 0, 0, 1, s, vm, lk, 1, w, none);
    endtask

    task automatic touch(input int s, input int w);
        drive_cycle(0, 0, 1, s, w, 0, 0, '1, '0, 0, 0, 0);
    endtask

    // Every expected result must appear exactly one cycle after its request.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (victim_vld_o !== 1'b1 || int'(victim_way_o) != e.way ||
                victim_none_o !== e.none) begin
                errors++;
                $display("FAIL victim: got vld=%0b way=%0d none=%0b, expected vld=1 way=%0d none=%0b at %0t",
                         victim_vld_o, victim_way_o, victim_none_o, e.way, e.none, $time);
            end
        end else if (victim_vld_o !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_vld: got vld=%0b, expected 0 at %0t", victim_vld_o, $time);
        end
    end

    initial begin
        int n;
        @(posedge clk);
        #1;
        drive_cycle(1, 0, 0, 0, 0, 0, 0, '1, '0, 0, 0, 0);

        // Sweep length after reset; a request during the sweep must be ignored.
        n = 0;
        while (busy_o && n < 200) begin
            drive_cycle(0, 0, 0, 0, 0, (n == 3), 1, '1, '0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n != SETS) begin
            errors++;
            $display("FAIL sweep_len: busy for %0d cycles, expected %0d", n, SETS);
        end

        // Invalid-first selection.
        req_exp(3, 8'b1111_0101, 8'b0000_0000, 1, 0);
        req_exp(3, 8'b1111_0101, 8'b0000_0010, 3, 0);

        // Tree order after touching every way.
        for (int w = 0; w < WAYS; w++) touch(5, w);
        req_exp(5, '1, '0, 0, 0);
        touch(5, 0);
        req_exp(5, '1, '0, 4, 0);

        // Lock steering and all-locked.
        req_exp(10, '1, 8'hFF, 0, 1);
        req_exp(10, '1, 8'h0F, 4, 0);

        // Touch and request colliding on one set.
        drive_cycle(0, 0, 1, 11, 2, 1, 11, '1, '0, 1, 0, 0);
        idle(1);
        req_exp(11, '1, '0, 4, 0);
        idle(1);

        // Back-to-back requests on a fresh set.
        req_exp(12, '1, '0, 0, 0);
`ifdef CPU64_L1_PLRU_VICTIM_TOUCH_EN
        req_exp(12, '1, '0, 4, 0);
`else
        req_exp(12, '1, '0, 0, 0);
`endif
        idle(2);

        // Random traffic over a few sets so touches and requests collide.
        for (int i = 0; i < 800; i++) begin
            logic [WAYS-1:0] vm;
            logic [WAYS-1:0] lk;
            int r;
            r  = $urandom_range(0, 99);
            vm = (r < 70) ? '1 : WAYS'($urandom);
            r  = $urandom_range(0, 99);
            lk = (r < 55) ? '0 : (r < 65) ? '1 : WAYS'($urandom);
            drive_cycle(0, ($urandom_range(0, 299) == 0), $urandom_range(0, 1),
                        $urandom_range(0, 3), $urandom_range(0, WAYS - 1),
                        ($urandom_range(0, 99) < 60), $urandom_range(0, 3), vm, lk, 0, 0, 0);
        end
        idle(2);

        // Reset right behind a request: the in-flight pulse shows, then the sweep restarts.
        drive_cycle(0, 0, 1, 2, 5, 1, 2, '1, '0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 1, 2, '1, '0, 0, 0, 0);
        n = 0;
        while (busy_o && n < 200) begin
            idle(1);
            n++;
        end
        checks++;
        if (n != SETS) begin
            errors++;
            $display("FAIL resweep_len: busy for %0d cycles, expected %0d", n, SETS);
        end
        req_exp(2, '1, '0, 0, 0);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
